seg7_score_scan: RTL
====================

# seg7_score_scan

Time-multiplexed driver for the board's 4-digit, common-anode seven-segment display, showing the Pong score as left score on digits 3–2 and right score on digits 1–0. The game logic strobes in new binary scores. The block converts them to BCD sequentially, then continuously scans the four digits, all from registered outputs. It is the output end of the board I/O path, the counterpart to the input flip-flop and synchronizer stage, and sits between the score counters and the top-level pins.

## Interface
- DIGIT_CYCLES, 100_000, clk cycles each digit stays lit (1 ms at 100 MHz)
- BLINK_CYCLES, 25_000_000, half-period of the winner blink
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- score_l  in  7  left score, binary
- score_r  in  7  right score, binary
- load  in  1  single-cycle strobe; latches score_l/score_r
- win_l  in  1  level; blink left digits
- win_r  in  1  level; blink right digits
- busy  out  1  conversion in progress
- an  out  4  digit enables, active-low, an[0] = rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- Conversion FSM states: IDLE, CONV_L, CONV_R, COMMIT.
- IDLE: on load, capture both scores and go to CONV_L.
- CONV_L: runs exactly 10 cycles. Each cycle, if the working value is ≥ 10, subtract 10 and increment the tens digit. After 10 cycles, go to CONV_R.
- CONV_R: same as CONV_L, applied to the right score. After 10 cycles, go to COMMIT.
- COMMIT: copy all four BCD digits into the display registers in one cycle, then go to IDLE.
- Any score > 99 displays as two dashes (segment g only) on that side.
- load while busy: discard the current conversion, recapture the new scores, restart at CONV_L. The display registers are not touched until COMMIT.
- Scan order: an[0] → an[1] → an[2] → an[3] → an[0], each digit lit for DIGIT_CYCLES cycles, exactly one anode low at a time.
- Tens digit equal to 0 is blanked (all segments off) on either side.
- dp is lit only while an[2] is active, acting as the separator.
- Blink counter toggles a phase bit every BLINK_CYCLES cycles. It runs freely and is cleared only by rst.
- While the phase bit is 1:
  - win_l = 1 forces seg = 7'h7F and dp = 1 for digits 3 and 2.
  - win_r = 1 does the same for digits 1 and 0.

## Timing
- Reset values:
  - an = 4'b1110, seg = 7'b1000000 (digit "0"), dp = 1, busy = 0.
  - Display registers hold 0/0, so the display reads " 0. 0" (blank, 0 with dp, blank, 0).
  - FSM in IDLE; scan and blink counters at 0; blink phase 0.
- an, seg, dp and busy are registered; no combinational path from inputs to outputs.
- load sampled high on cycle N:
  - busy = 1 from cycle N+1 through the COMMIT cycle N+21.
  - New digit values appear on seg from cycle N+22, as each digit comes up in the scan.
- The scan counter is independent of conversion; load never resets the scan.
- The digit index wraps from 3 to 0 with no idle gap.
- rst mid-conversion aborts it. The display returns to 0/0 and the load is lost.
- rst has priority over load on the same cycle.
- Score 99 converts correctly within the 10-cycle window: at most 9 subtractions.

## Structure
- Shared package seg7_pkg:
  - 16-entry active-low segment pattern constant for 0–9.
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'b0111111.
  - FSM state enum.
  - Digit index constants DIG_RU=0, DIG_RT=1, DIG_LU=2, DIG_LT=3.
- Sub-module bin2bcd_seq: one 10-cycle subtractive converter, 7-bit value in, tens/units/overflow out. It is instantiated once and time-shared between CONV_L and CONV_R.
- Top level holds the FSM, the display registers, the scan counter, the blink counter and the output registers.

## Test plan
(Bench parameters: DIGIT_CYCLES=4, BLINK_CYCLES=16.)
- Reset release, then observe 16 cycles -> an cycles 1110, 1101, 1011, 0111, 4 cycles each. seg is 1000000 on an[0] and an[2] and blank on an[1] and an[3]. dp = 0 only while an[2] is active.
- load with score_l=47, score_r=5 at cycle N -> busy high for cycles N+1..N+21. From N+22, digits 3..0 show 4, 7., blank, 5: patterns 0011001, 1111000, 1111111, 0010010.
- load with score_l=99, score_r=100 -> left shows 9 9. with 0010000 on each digit; right shows two dashes, 0111111 on each.
- load 12/34, then load 56/78 at N+8 -> the 12/34 values never appear on seg. The 56/78 values appear from cycle (N+8)+22, and busy stays high continuously.
- win_l=1 with score 10/3 -> digits 3–2 alternate between 1, 0. and blank every 16 cycles, dp included. Digits 1–0 stay steady.
- rst asserted at N+10 of a conversion -> busy=0 the next cycle, display 0/0, outputs equal to the reset values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the score display: segment patterns,
// conversion FSM states, BCD digit bundle and scan digit indices.
package seg7_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}; entry 0 is digit "0".
    // Codes 10..15 never occur in a valid BCD digit and show blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV_L,
        CONV_R,
        COMMIT
    } conv_state_t;

    typedef struct packed {
        logic       ovf;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    localparam logic [1:0] DIG_RU = 2'd0;
    localparam logic [1:0] DIG_RT = 2'd1;
    localparam logic [1:0] DIG_LU = 2'd2;
    localparam logic [1:0] DIG_LT = 2'd3;

    // Pattern for one digit position of one side of the score.
    function automatic logic [6:0] digit_seg(bcd_t v, logic is_tens);
        logic [6:0] s;
        s = SEG_LUT[v.units];
        if (v.ovf)
            s = SEG_DASH;
        else if (is_tens)
            s = (v.tens == 4'd0) ? SEG_BLANK : SEG_LUT[v.tens];
        return s;
    endfunction

endpackage

// File: rtl/seg7_score_scan_bin2bcd.sv
// Sequential subtractive binary-to-BCD converter for 0..99.
// Ports: clk, rst, start/val (load a new value), tens/units/ovf result.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] val,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       ovf
);

    logic [6:0] work;

    // One subtraction of ten per cycle; stops by itself once the
    // remainder is a single digit, so the result then holds steady.
    always_ff @(posedge clk) begin
        if (rst) begin
            work <= '0;
            tens <= '0;
            ovf  <= 1'b0;
        end else if (start) begin
            work <= val;
            tens <= '0;
            ovf  <= (val > 7'd99);
        end else if (work >= 7'd10) begin
            work <= work - 7'd10;
            tens <= tens + 4'd1;
        end
    end

    assign units = work[3:0];

endmodule

// File: rtl/seg7_score_scan.sv
// Four-digit multiplexed score display: BCD conversion FSM, display
// registers, digit scan, winner blink and registered an/seg/dp/busy.
module seg7_score_scan
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] score_l,
    input  logic [6:0] score_r,
    input  logic       load,
    input  logic       win_l,
    input  logic       win_r,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(DIGIT_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);

    conv_state_t   state, state_n;
    logic [3:0]    step, step_n;
    logic [6:0]    sr_q;
    bcd_t          pl, dl, dr, dl_n, dr_n, cv, side;
    logic          conv_start, cap_l, commit;
    logic [6:0]    conv_val;
    logic [3:0]    cv_tens, cv_units;
    logic          cv_ovf;

    logic [SW-1:0] scnt, scnt_n;
    logic [1:0]    dig, dig_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n, win_s;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .val   (conv_val),
        .tens  (cv_tens),
        .units (cv_units),
        .ovf   (cv_ovf)
    );

    assign cv = {cv_ovf, cv_tens, cv_units};

    // A load in any state restarts conversion of the new pair. The left
    // result is final after nine steps, so the tenth CONV_L cycle both
    // captures it and restarts the converter on the right score.
    always_comb begin
        state_n    = state;
        step_n     = step;
        conv_start = 1'b0;
        conv_val   = score_l;
        cap_l      = 1'b0;
        commit     = 1'b0;
        if (load) begin
            state_n    = CONV_L;
            step_n     = '0;
            conv_start = 1'b1;
        end else begin
            unique case (state)
                IDLE: ;
                CONV_L: begin
                    if (step == 4'd9) begin
                        state_n    = CONV_R;
                        step_n     = '0;
                        conv_start = 1'b1;
                        conv_val   = sr_q;
                        cap_l      = 1'b1;
                    end else begin
                        step_n = step + 4'd1;
                    end
                end
                CONV_R: begin
                    if (step == 4'd9) begin
                        state_n = COMMIT;
                        step_n  = '0;
                    end else begin
                        step_n = step + 4'd1;
                    end
                end
                COMMIT: begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Display, scan and blink next values; the output registers are
    // loaded from these so a commit shows up in the very next cycle.
    always_comb begin
        dl_n = dl;
        dr_n = dr;
        if (commit) begin
            dl_n = pl;
            dr_n = cv;
        end
        scnt_n  = (scnt == S_LAST) ? '0 : scnt + 1'b1;
        dig_n   = (scnt == S_LAST) ? dig + 2'd1 : dig;
        bcnt_n  = (bcnt == B_LAST) ? '0 : bcnt + 1'b1;
        phase_n = (bcnt == B_LAST) ? ~phase : phase;

        side  = dig_n[1] ? dl_n : dr_n;
        win_s = dig_n[1] ? win_l : win_r;
        an_d  = ~(4'b0001 << dig_n);
        seg_d = digit_seg(side, dig_n == DIG_LT || dig_n == DIG_RT);
        dp_d  = (dig_n != DIG_LU);
        if (phase_n && win_s) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            sr_q  <= '0;
            pl    <= '0;
            dl    <= '0;
            dr    <= '0;
            scnt  <= '0;
            dig   <= DIG_RU;
            bcnt  <= '0;
            phase <= 1'b0;
            an    <= 4'b1110;
            seg   <= SEG_LUT[0];
            dp    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            step  <= step_n;
            if (load)
                sr_q <= score_r;
            if (cap_l)
                pl <= cv;
            dl    <= dl_n;
            dr    <= dr_n;
            scnt  <= scnt_n;
            dig   <= dig_n;
            bcnt  <= bcnt_n;
            phase <= phase_n;
            an    <= an_d;
            seg   <= seg_d;
            dp    <= dp_d;
            busy  <= (state_n != IDLE);
        end
    end

endmodule
